// File: rtl/serial_mem_bridge_if.sv
// Byte-UART, processor-pause and external-memory signals of the serial memory bridge.
// master = bridge side, slave = UART/processor/memory side.
interface serial_mem_bridge_if #(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_BYTES = 4
);
   logic [7:0]              rx_data;
   logic                    rx_valid;
   logic [7:0]              tx_data;
   logic                    tx_start;
   logic                    tx_ready;
   logic                    pause_req;
   logic                    pause_ack;
   logic                    mem_ctrl;
   logic [8*ADDR_BYTES-1:0] mem_addr;
   logic [8*DATA_BYTES-1:0] mem_wdata;
   logic                    mem_write;
   logic                    mem_read;
   logic [8*DATA_BYTES-1:0] mem_rdata;
   logic                    force_rst;
   logic                    busy;
   logic                    error;

   modport master (
      input  rx_data, rx_valid, tx_ready, pause_ack, mem_rdata,
      output tx_data, tx_start, pause_req, mem_ctrl, mem_addr, mem_wdata,
             mem_write, mem_read, force_rst, busy, error
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, pause_ack, mem_rdata,
      input  tx_data, tx_start, pause_req, mem_ctrl, mem_addr, mem_wdata,
             mem_write, mem_read, force_rst, busy, error
   );
endinterface

// File: rtl/serial_mem_bridge.sv
// UART command bridge to processor memory: burst write/read, processor reset control, ping.
// Optional inter-byte timeout abort with NAK when RX_TIMEOUT_EN is defined.
module serial_mem_bridge #(
   parameter int DATA_BYTES     = 4,
   parameter int ADDR_BYTES     = 4,
   parameter int MEM_LATENCY    = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   serial_mem_bridge_if.master br
);
   localparam int DW = 8 * DATA_BYTES;
   localparam int AW = 8 * ADDR_BYTES;

   typedef enum logic [3:0] {
      IDLE, ADDR, LEN, WDATA, PAUSE, MEM_WR, MEM_RD, TX_WORD, TX_ACK
   } state_t;

   state_t          state_q, state_d;
   logic            is_wr_q, is_wr_d;
   logic            first_q, first_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      bcnt_q, bcnt_d;
   logic [15:0]     lat_q, lat_d;
   logic [7:0]      resp_q, resp_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;
   logic            pause_q, pause_d;
   logic            mctl_q, mctl_d;
   logic            mwr_q, mwr_d;
   logic            mrd_q, mrd_d;
   logic            frst_q, frst_d;
   logic            err_q, err_d;
`ifdef RX_TIMEOUT_EN
   logic [31:0]     to_q, to_d;
`endif

   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      first_d    = first_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      bcnt_d     = bcnt_q;
      lat_d      = lat_q;
      resp_d     = resp_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      pause_d    = pause_q;
      mctl_d     = mctl_q;
      mwr_d      = 1'b0;
      mrd_d      = mrd_q;
      frst_d     = frst_q;
      err_d      = err_q;
`ifdef RX_TIMEOUT_EN
      to_d       = '0;
`endif
      case (state_q)
         IDLE: if (br.rx_valid) begin
            bcnt_d = '0;
            resp_d = 8'h06;
            case (br.rx_data)
               8'h01: begin is_wr_d = 1'b1; state_d = ADDR; end
               8'h02: begin is_wr_d = 1'b0; state_d = ADDR; end
               8'h03: begin frst_d = 1'b0; state_d = TX_ACK; end
               8'h04: begin frst_d = 1'b1; state_d = TX_ACK; end
               8'h05: begin err_d = 1'b0; state_d = TX_ACK; end
               default: begin err_d = 1'b1; resp_d = 8'h15; state_d = TX_ACK; end
            endcase
         end
         ADDR: if (br.rx_valid) begin
            addr_d = (addr_q << 8) | AW'(br.rx_data);
            bcnt_d = bcnt_q + 8'd1;
            if (bcnt_q == 8'(ADDR_BYTES - 1)) begin
               bcnt_d  = '0;
               state_d = LEN;
            end
         end
         LEN: if (br.rx_valid) begin
            cnt_d   = br.rx_data;
            first_d = 1'b1;
            if (is_wr_q) begin
               state_d = WDATA;
            end else begin
               pause_d = 1'b1;
               state_d = PAUSE;
            end
         end
         WDATA: if (br.rx_valid) begin
            wdata_d = (wdata_q << 8) | DW'(br.rx_data);
            bcnt_d  = bcnt_q + 8'd1;
            if (bcnt_q == 8'(DATA_BYTES - 1)) begin
               bcnt_d = '0;
               // Only the first word needs the pause handshake; later words reuse it.
               if (first_q) begin
                  pause_d = 1'b1;
                  state_d = PAUSE;
               end else begin
                  mwr_d   = 1'b1;
                  state_d = MEM_WR;
               end
            end
         end
         PAUSE: if (br.pause_ack) begin
            mctl_d = 1'b1;
            if (is_wr_q) begin
               mwr_d   = 1'b1;
               state_d = MEM_WR;
            end else begin
               mrd_d   = 1'b1;
               lat_d   = '0;
               state_d = MEM_RD;
            end
         end
         MEM_WR: begin
            addr_d  = addr_q + AW'(DATA_BYTES);
            first_d = 1'b0;
            if (cnt_q == 8'd0) begin
               pause_d = 1'b0;
               mctl_d  = 1'b0;
               state_d = TX_ACK;
            end else begin
               cnt_d   = cnt_q - 8'd1;
               state_d = WDATA;
            end
         end
         MEM_RD: begin
            if (lat_q == 16'(MEM_LATENCY - 1)) begin
               rdata_d = br.mem_rdata;
               mrd_d   = 1'b0;
               bcnt_d  = '0;
               state_d = TX_WORD;
            end else begin
               lat_d = lat_q + 16'd1;
            end
         end
         TX_WORD: if (!tx_start_q && br.tx_ready) begin
            tx_start_d = 1'b1;
            tx_data_d  = rdata_q[DW-1 -: 8];
            rdata_d    = rdata_q << 8;
            bcnt_d     = bcnt_q + 8'd1;
            if (bcnt_q == 8'(DATA_BYTES - 1)) begin
               addr_d = addr_q + AW'(DATA_BYTES);
               if (cnt_q == 8'd0) begin
                  pause_d = 1'b0;
                  mctl_d  = 1'b0;
                  state_d = TX_ACK;
               end else begin
                  cnt_d   = cnt_q - 8'd1;
                  mrd_d   = 1'b1;
                  lat_d   = '0;
                  state_d = MEM_RD;
               end
            end
         end
         TX_ACK: if (!tx_start_q && br.tx_ready) begin
            tx_start_d = 1'b1;
            tx_data_d  = resp_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (br.rx_valid && (state_q inside {PAUSE, MEM_WR, MEM_RD, TX_WORD, TX_ACK}))
         err_d = 1'b1;

`ifdef RX_TIMEOUT_EN
      if (state_q inside {ADDR, LEN, WDATA}) begin
         if (br.rx_valid) begin
            to_d = '0;
         end else if (to_q == 32'(TIMEOUT_CYCLES - 1)) begin
            pause_d = 1'b0;
            mctl_d  = 1'b0;
            err_d   = 1'b1;
            resp_d  = 8'h15;
            state_d = TX_ACK;
         end else begin
            to_d = to_q + 32'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         is_wr_q    <= 1'b0;
         first_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         cnt_q      <= '0;
         bcnt_q     <= '0;
         lat_q      <= '0;
         resp_q     <= 8'h06;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         pause_q    <= 1'b0;
         mctl_q     <= 1'b0;
         mwr_q      <= 1'b0;
         mrd_q      <= 1'b0;
         frst_q     <= 1'b1;
         err_q      <= 1'b0;
`ifdef RX_TIMEOUT_EN
         to_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         first_q    <= first_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         cnt_q      <= cnt_d;
         bcnt_q     <= bcnt_d;
         lat_q      <= lat_d;
         resp_q     <= resp_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         pause_q    <= pause_d;
         mctl_q     <= mctl_d;
         mwr_q      <= mwr_d;
         mrd_q      <= mrd_d;
         frst_q     <= frst_d;
         err_q      <= err_d;
`ifdef RX_TIMEOUT_EN
         to_q       <= to_d;
`endif
      end
   end

   assign br.tx_data   = tx_data_q;
   assign br.tx_start  = tx_start_q;
   assign br.pause_req = pause_q;
   assign br.mem_ctrl  = mctl_q;
   assign br.mem_addr  = addr_q;
   assign br.mem_wdata = wdata_q;
   assign br.mem_write = mwr_q;
   assign br.mem_read  = mrd_q;
   assign br.force_rst = frst_q;
   assign br.busy      = (state_q != IDLE);
   assign br.error     = err_q;
endmodule

// File: tb/tb_serial_mem_bridge.sv
// Directed bench for serial_mem_bridge with a command-level reference model and per-cycle monitor.
module tb_serial_mem_bridge;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_mem_bridge_if #(.DATA_BYTES(4), .ADDR_BYTES(4)) bif ();

   serial_mem_bridge #(
      .DATA_BYTES(4), .ADDR_BYTES(4), .MEM_LATENCY(LAT), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .br  (bif)
   );

   int tests = 0;
   int fails = 0;

   logic [7:0]  cmd[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_wa[$];
   logic [31:0] exp_wd[$];
   logic [31:0] exp_ra[$];
   logic [7:0]  obs_tx[$];
   logic [31:0] obs_wa[$];
   logic [31:0] env_mem[logic [31:0]];
   logic [31:0] mod_mem[logic [31:0]];
   logic        model_err = 1'b0;
   logic        model_frc = 1'b1;
   int          pause_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic fail_now(input string nm);
      tests++;
      fails++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hC3C3_0000;
   endfunction

   // Transmitter: busy for three cycles after each start strobe.
   initial begin
      bif.tx_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         if (bif.tx_start) begin
            bif.tx_ready = 1'b0;
            repeat (3) @(posedge clk);
            #2 bif.tx_ready = 1'b1;
         end
      end
   end

   // Processor: acknowledges a pause two cycles after it is requested.
   initial begin
      int pc;
      pc = 0;
      bif.pause_ack = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (!bif.pause_req) begin
            bif.pause_ack = 1'b0;
            pc = 0;
         end else if (pc < 2) pc++;
         else bif.pause_ack = 1'b1;
      end
   end

   // Memory: read data is valid only once mem_read has been high LAT cycles.
   initial begin
      int run;
      run = 0;
      bif.mem_rdata = 32'hA5A5_A5A5;
      forever begin
         @(negedge clk);
         if (bif.mem_write) env_mem[bif.mem_addr] = bif.mem_wdata;
         if (bif.mem_read) run++; else run = 0;
         if (run == LAT)
            bif.mem_rdata = env_mem.exists(bif.mem_addr) ? env_mem[bif.mem_addr] : dflt(bif.mem_addr);
         else
            bif.mem_rdata = 32'hA5A5_A5A5;
      end
   end

   // Compare process: checks every observable event against the model queues.
   initial begin
      logic mr_p, mc_p, ack_p, rdy_p;
      int   rlen;
      mr_p = 0; mc_p = 0; ack_p = 0; rdy_p = 1; rlen = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mr_p = 0; mc_p = 0; ack_p = 0; rdy_p = 1; rlen = 0;
         end else begin
            if (bif.pause_req) pause_seen++;
            if (bif.tx_start) begin
               obs_tx.push_back(bif.tx_data);
               chk("tx_start_while_ready", {31'd0, rdy_p}, 32'd1);
               if (exp_tx.size() == 0) fail_now("unexpected_tx_byte");
               else chk("tx_byte", {24'd0, bif.tx_data}, {24'd0, exp_tx.pop_front()});
            end
            if (bif.mem_write) begin
               obs_wa.push_back(bif.mem_addr);
               chk("wr_mem_ctrl", {31'd0, bif.mem_ctrl}, 32'd1);
               if (exp_wa.size() == 0) fail_now("unexpected_mem_write");
               else begin
                  chk("wr_addr", bif.mem_addr, exp_wa.pop_front());
                  chk("wr_data", bif.mem_wdata, exp_wd.pop_front());
               end
            end
            if (bif.mem_read && !mr_p) begin
               chk("rd_mem_ctrl", {31'd0, bif.mem_ctrl}, 32'd1);
               if (exp_ra.size() == 0) fail_now("unexpected_mem_read");
               else chk("rd_addr", bif.mem_addr, exp_ra.pop_front());
            end
            if (bif.mem_read) rlen++;
            if (mr_p && !bif.mem_read) begin
               chk("rd_len", rlen, LAT);
               rlen = 0;
            end
            if (bif.mem_ctrl && !mc_p) chk("mem_ctrl_after_ack", {31'd0, ack_p}, 32'd1);
            if (!bif.busy) chk("idle_port_released", {30'd0, bif.pause_req, bif.mem_ctrl}, 32'd0);
            mr_p  = bif.mem_read;
            mc_p  = bif.mem_ctrl;
            ack_p = bif.pause_ack;
            rdy_p = bif.tx_ready;
         end
      end
   end

   // Reference model: expected effects of one complete command held in cmd.
   task automatic model_cmd();
      logic [31:0] a, d;
      int n;
      case (cmd[0])
         8'h01: begin
            a = {cmd[1], cmd[2], cmd[3], cmd[4]};
            n = int'(cmd[5]);
            for (int i = 0; i <= n; i++) begin
               d = {cmd[6+4*i], cmd[7+4*i], cmd[8+4*i], cmd[9+4*i]};
               exp_wa.push_back(a);
               exp_wd.push_back(d);
               mod_mem[a] = d;
               a = a + 32'd4;
            end
            exp_tx.push_back(8'h06);
         end
         8'h02: begin
            a = {cmd[1], cmd[2], cmd[3], cmd[4]};
            n = int'(cmd[5]);
            for (int i = 0; i <= n; i++) begin
               d = mod_mem.exists(a) ? mod_mem[a] : dflt(a);
               exp_ra.push_back(a);
               for (int k = 3; k >= 0; k--) exp_tx.push_back(d[8*k +: 8]);
               a = a + 32'd4;
            end
            exp_tx.push_back(8'h06);
         end
         8'h03: begin model_frc = 1'b0; exp_tx.push_back(8'h06); end
         8'h04: begin model_frc = 1'b1; exp_tx.push_back(8'h06); end
         8'h05: begin model_err = 1'b0; exp_tx.push_back(8'h06); end
         default: begin model_err = 1'b1; exp_tx.push_back(8'h15); end
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bif.rx_data  = b;
      bif.rx_valid = 1'b1;
      @(posedge clk); #1;
      bif.rx_valid = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic send_cmd();
      foreach (cmd[i]) send_byte(cmd[i]);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((bif.busy || exp_tx.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now("command_completion_timeout");
      repeat (8) @(negedge clk);
      chk("queues_drained", exp_tx.size() + exp_wa.size() + exp_ra.size(), 0);
      chk("error_flag", {31'd0, bif.error}, {31'd0, model_err});
      chk("force_rst", {31'd0, bif.force_rst}, {31'd0, model_frc});
      chk("busy_after_cmd", {31'd0, bif.busy}, 32'd0);
   endtask

   task automatic run_cmd();
      model_cmd();
      send_cmd();
      wait_done();
   endtask

   task automatic flush_model();
      exp_tx.delete(); exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
      model_err = 1'b0;
      model_frc = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tx_data"},   {24'd0, bif.tx_data}, 32'd0);
      chk({tag, "_tx_start"},  {31'd0, bif.tx_start}, 32'd0);
      chk({tag, "_pause_req"}, {31'd0, bif.pause_req}, 32'd0);
      chk({tag, "_mem_ctrl"},  {31'd0, bif.mem_ctrl}, 32'd0);
      chk({tag, "_mem_addr"},  bif.mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, bif.mem_wdata, 32'd0);
      chk({tag, "_mem_rw"},    {30'd0, bif.mem_write, bif.mem_read}, 32'd0);
      chk({tag, "_force_rst"}, {31'd0, bif.force_rst}, 32'd1);
      chk({tag, "_busy"},      {31'd0, bif.busy}, 32'd0);
      chk({tag, "_error"},     {31'd0, bif.error}, 32'd0);
   endtask

   initial begin
      int base, ps, n;
      logic [7:0] rd_lit [9];
      bif.rx_data  = 8'h00;
      bif.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // PING: single ACK, no pause.
      base = obs_tx.size(); ps = pause_seen;
      cmd = '{8'h05};
      run_cmd();
      chk("ping_bytes", obs_tx.size() - base, 1);
      if (obs_tx.size() > base) chk("ping_ack", {24'd0, obs_tx[base]}, 32'h06);
      chk("ping_no_pause", pause_seen - ps, 0);

      // Two-word burst write.
      ps = pause_seen;
      cmd = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01,
              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
      run_cmd();
      chk("wr_pause_seen", {31'd0, (pause_seen > ps)}, 32'd1);
      chk("mem_0x10", env_mem.exists(32'h10) ? env_mem[32'h10] : 32'hX, 32'hDEAD_BEEF);
      chk("mem_0x14", env_mem.exists(32'h14) ? env_mem[32'h14] : 32'hX, 32'h1234_5678);

      // Read the same two words back.
      base = obs_tx.size();
      rd_lit = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h06};
      cmd = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01};
      run_cmd();
      chk("rd_byte_count", obs_tx.size() - base, 9);
      if (obs_tx.size() >= base + 9)
         for (int i = 0; i < 9; i++) chk("rd_literal", {24'd0, obs_tx[base+i]}, {24'd0, rd_lit[i]});

      // Address wraps past the top of the address space.
      base = obs_wa.size();
      cmd = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h01,
              8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
      run_cmd();
      chk("wrap_count", obs_wa.size() - base, 2);
      if (obs_wa.size() >= base + 2) begin
         chk("wrap_addr0", obs_wa[base], 32'hFFFF_FFFC);
         chk("wrap_addr1", obs_wa[base+1], 32'h0000_0000);
      end

      // Processor reset control, bad opcode, error clear.
      cmd = '{8'h03}; run_cmd();
      chk("rst_assert_lit", {31'd0, bif.force_rst}, 32'd0);
      cmd = '{8'h04}; run_cmd();
      chk("rst_release_lit", {31'd0, bif.force_rst}, 32'd1);
      base = obs_tx.size();
      cmd = '{8'h7F}; run_cmd();
      chk("nak_lit", {24'd0, obs_tx[obs_tx.size()-1]}, 32'h15);
      chk("nak_error_lit", {31'd0, bif.error}, 32'd1);
      cmd = '{8'h05}; run_cmd();
      chk("ping_clears_error_lit", {31'd0, bif.error}, 32'd0);

      // Reset in the middle of a read burst after three bytes went out.
      cmd = '{8'h03}; run_cmd();
      cmd = '{8'h7F}; run_cmd();
      base = obs_tx.size();
      cmd = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01};
      model_cmd();
      send_cmd();
      n = 0;
      while (obs_tx.size() < base + 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) fail_now("mid_read_bytes_timeout");
      chk("mid_read_paused", {31'd0, bif.mem_ctrl}, 32'd1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      flush_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("no_tx_after_rst", obs_tx.size() - base, 3);
      cmd = '{8'h05}; run_cmd();
      chk("ping_after_rst", {24'd0, obs_tx[obs_tx.size()-1]}, 32'h06);

      // Partial command followed by silence.
      base = obs_tx.size();
`ifdef RX_TIMEOUT_EN
      exp_tx.push_back(8'h15);
      model_err = 1'b1;
`endif
      send_byte(8'h02);
      send_byte(8'h00);
`ifdef RX_TIMEOUT_EN
      wait_done();
      chk("timeout_nak", {24'd0, obs_tx[obs_tx.size()-1]}, 32'h15);
      chk("timeout_error", {31'd0, bif.error}, 32'd1);
`else
      repeat (300) @(negedge clk);
      chk("partial_still_busy", {31'd0, bif.busy}, 32'd1);
      chk("partial_no_tx", obs_tx.size() - base, 0);
      @(posedge clk); #3;
      rst = 1'b1;
      flush_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit");
      $fatal(1, "simulation time limit");
   end
endmodule
